// File: rtl/sdram_arb2_if.sv
// Single-request SDRAM handshake bundle: addr/r/w/dw toward the target,
// dr/busy back toward the requester. The same bundle is used on both sides
// of the arbiter (requester ports and the controller port).
interface sdram_arb2_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] addr;
    logic              r;
    logic              w;
    logic [DATA_W-1:0] dw;
    logic [DATA_W-1:0] dr;
    logic              busy;

    // Requester side: issues requests, observes busy and read data.
    modport master (output addr, output r, output w, output dw,
                    input  dr,   input  busy);

    // Target side: receives requests, reports busy and read data.
    modport slave  (input  addr, input  r, input  w, input  dw,
                    output dr,   output busy);
endinterface

// File: rtl/sdram_arb2.sv
// Two-port round-robin arbiter in front of one SDRAM controller.
// Each port latches a single one-cycle request into a pending register;
// the FSM grants one pending port at a time, pulses m_r/m_w for one cycle,
// follows m_busy high then low, and returns read data to the granted port.
module sdram_arb2 #(
    parameter int bankBits = 2,
    parameter int rowBits  = 13,
    parameter int colBits  = 9,
    parameter int dataBits = 16
) (
    input  logic         clk,
    input  logic         rstn,
    sdram_arb2_if.slave  p0,
    sdram_arb2_if.slave  p1,
    sdram_arb2_if.master m
);
    localparam int addrBits = bankBits + rowBits + colBits;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            pend_q, pend_d;
    logic [1:0]            op_rd_q, op_rd_d;
    logic [addrBits-1:0]   paddr_q [2];
    logic [addrBits-1:0]   paddr_d [2];
    logic [dataBits-1:0]   pdw_q [2];
    logic [dataBits-1:0]   pdw_d [2];
    logic [dataBits-1:0]   dr_q [2];
    logic [dataBits-1:0]   dr_d [2];
    logic                  gnt_q, gnt_d;     // port currently granted
    logic                  prio_q, prio_d;   // port preferred when both pend
    logic [addrBits-1:0]   m_addr_q, m_addr_d;
    logic [dataBits-1:0]   m_dw_q, m_dw_d;
    logic                  m_r_q, m_r_d;
    logic                  m_w_q, m_w_d;

    logic [1:0]            rq_r_s, rq_w_s;
    logic [addrBits-1:0]   rq_addr_s [2];
    logic [dataBits-1:0]   rq_dw_s [2];
    logic                  sel_s;

    // Gather both request ports into indexable form.
    always_comb begin
        rq_r_s       = {p1.r, p0.r};
        rq_w_s       = {p1.w, p0.w};
        rq_addr_s[0] = p0.addr;
        rq_addr_s[1] = p1.addr;
        rq_dw_s[0]   = p0.dw;
        rq_dw_s[1]   = p1.dw;
    end

    // Next-state logic: request capture, grant selection and handshake.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        op_rd_d  = op_rd_q;
        paddr_d  = paddr_q;
        pdw_d    = pdw_q;
        dr_d     = dr_q;
        gnt_d    = gnt_q;
        prio_d   = prio_q;
        m_addr_d = m_addr_q;
        m_dw_d   = m_dw_q;
        m_r_d    = 1'b0;
        m_w_d    = 1'b0;
        sel_s    = 1'b0;

        // A port only accepts a pulse while it has nothing pending; read wins
        // when r and w arrive together.
        for (int i = 0; i < 2; i++) begin
            if (!pend_q[i] && (rq_r_s[i] || rq_w_s[i])) begin
                pend_d[i]  = 1'b1;
                op_rd_d[i] = rq_r_s[i];
                paddr_d[i] = rq_addr_s[i];
                pdw_d[i]   = rq_dw_s[i];
            end else begin
                pend_d[i]  = pend_d[i];
            end
        end

        case (state_q)
            IDLE: begin
                if ((pend_q != 2'b00) && !m.busy) begin
                    if (pend_q == 2'b11) begin
                        sel_s = prio_q;
                    end else begin
                        sel_s = pend_q[1];
                    end
                    gnt_d    = sel_s;
                    prio_d   = ~sel_s;
                    m_addr_d = paddr_q[sel_s];
                    m_dw_d   = pdw_q[sel_s];
                    m_r_d    = op_rd_q[sel_s];
                    m_w_d    = ~op_rd_q[sel_s];
                    state_d  = ISSUE;
                end else begin
                    state_d  = IDLE;
                end
            end
            ISSUE: begin
                // The r/w pulse is visible during this state only.
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (m.busy) begin
                    state_d = WAIT_LO;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (!m.busy) begin
                    if (op_rd_q[gnt_q]) begin
                        dr_d[gnt_q] = m.dr;
                    end else begin
                        dr_d[gnt_q] = dr_q[gnt_q];
                    end
                    pend_d[gnt_q] = 1'b0;
                    state_d       = IDLE;
                end else begin
                    state_d       = WAIT_LO;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            pend_q     <= 2'b00;
            op_rd_q    <= 2'b00;
            paddr_q[0] <= {addrBits{1'b0}};
            paddr_q[1] <= {addrBits{1'b0}};
            pdw_q[0]   <= {dataBits{1'b0}};
            pdw_q[1]   <= {dataBits{1'b0}};
            dr_q[0]    <= {dataBits{1'b0}};
            dr_q[1]    <= {dataBits{1'b0}};
            gnt_q      <= 1'b0;
            prio_q     <= 1'b0;
            m_addr_q   <= {addrBits{1'b0}};
            m_dw_q     <= {dataBits{1'b0}};
            m_r_q      <= 1'b0;
            m_w_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            op_rd_q    <= op_rd_d;
            paddr_q    <= paddr_d;
            pdw_q      <= pdw_d;
            dr_q       <= dr_d;
            gnt_q      <= gnt_d;
            prio_q     <= prio_d;
            m_addr_q   <= m_addr_d;
            m_dw_q     <= m_dw_d;
            m_r_q      <= m_r_d;
            m_w_q      <= m_w_d;
        end
    end

    assign p0.busy = pend_q[0];
    assign p1.busy = pend_q[1];
    assign p0.dr   = dr_q[0];
    assign p1.dr   = dr_q[1];
    assign m.addr  = m_addr_q;
    assign m.dw    = m_dw_q;
    assign m.r     = m_r_q;
    assign m.w     = m_w_q;
endmodule

// File: tb/tb_sdram_arb2.sv
// Directed bench for sdram_arb2 with a behavioural SDRAM controller model.
module tb_sdram_arb2;
    logic clk;
    logic rstn;

    sdram_arb2_if #(.ADDR_W(24), .DATA_W(16)) p0_if ();
    sdram_arb2_if #(.ADDR_W(24), .DATA_W(16)) p1_if ();
    sdram_arb2_if #(.ADDR_W(24), .DATA_W(16)) m_if ();

    sdram_arb2 dut (
        .clk  (clk),
        .rstn (rstn),
        .p0   (p0_if),
        .p1   (p1_if),
        .m    (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Controller model state and knobs.
    int          lat        = 3;
    logic        refresh    = 1'b0;
    logic        ctl_fix_en = 1'b0;
    logic [15:0] ctl_fix    = 16'h0000;
    logic        ctl_busy;
    int          ctl_cnt;
    logic [15:0] ctl_dr;
    logic [15:0] ctl_rd_val;
    int          n_rpulse = 0;
    int          n_wpulse = 0;
    logic [23:0] acc_q[$];

    assign m_if.busy = ctl_busy | refresh;
    assign m_if.dr   = ctl_dr;

    // Controller model: accepts r/w pulse when idle, busy for lat cycles.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctl_busy   <= 1'b0;
            ctl_cnt    <= 0;
            ctl_dr     <= 16'h0000;
            ctl_rd_val <= 16'h0000;
        end else if (ctl_busy) begin
            if (ctl_cnt == 1) begin
                ctl_busy <= 1'b0;
                ctl_dr   <= ctl_rd_val;
            end
            ctl_cnt <= ctl_cnt - 1;
        end else if ((m_if.r || m_if.w) && !m_if.busy) begin
            ctl_busy   <= 1'b1;
            ctl_cnt    <= lat;
            ctl_rd_val <= ctl_fix_en ? ctl_fix : (m_if.addr[15:0] ^ 16'hC3C3);
            acc_q.push_back(m_if.addr);
        end
    end

    // Count every cycle the arbiter drives a read or write pulse.
    always @(posedge clk) begin
        if (m_if.r) n_rpulse <= n_rpulse + 1;
        if (m_if.w) n_wpulse <= n_wpulse + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle request; caller is at a negedge.
    task automatic req(input int port, input logic rd, input logic wr,
                       input logic [23:0] a, input logic [15:0] d);
        if (port == 0) begin
            p0_if.r = rd; p0_if.w = wr; p0_if.addr = a; p0_if.dw = d;
        end else begin
            p1_if.r = rd; p1_if.w = wr; p1_if.addr = a; p1_if.dw = d;
        end
        @(negedge clk);
        p0_if.r = 1'b0; p0_if.w = 1'b0;
        p1_if.r = 1'b0; p1_if.w = 1'b0;
    endtask

    task automatic req2(input logic [23:0] a0, input logic [23:0] a1);
        p0_if.r = 1'b1; p0_if.addr = a0;
        p1_if.r = 1'b1; p1_if.addr = a1;
        @(negedge clk);
        p0_if.r = 1'b0; p1_if.r = 1'b0;
    endtask

    task automatic wait_mbusy(input logic val, input int budget);
        int n = 0;
        while (m_if.busy !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_if.busy !== val) check("mbusy_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_port_idle(input int port, input int budget);
        int n = 0;
        while (((port == 0) ? p0_if.busy : p1_if.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((port == 0) ? p0_if.busy : p1_if.busy) check("port_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((p0_if.busy || p1_if.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (p0_if.busy || p1_if.busy) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int s0;
        int bad;
        int base;
        rstn = 1'b0;
        p0_if.r = 1'b0; p0_if.w = 1'b0; p0_if.addr = 24'h0; p0_if.dw = 16'h0;
        p1_if.r = 1'b0; p1_if.w = 1'b0; p1_if.addr = 24'h0; p1_if.dw = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_p0_busy", {31'd0, p0_if.busy}, 32'd0);
        check("rst_p1_busy", {31'd0, p1_if.busy}, 32'd0);
        check("rst_p0_dr", {16'd0, p0_if.dr}, 32'd0);
        check("rst_p1_dr", {16'd0, p1_if.dr}, 32'd0);
        check("rst_m_r", {31'd0, m_if.r}, 32'd0);
        check("rst_m_w", {31'd0, m_if.w}, 32'd0);
        check("rst_m_addr", {8'd0, m_if.addr}, 32'd0);
        check("rst_m_dw", {16'd0, m_if.dw}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single read on p0 returning 0xBEEF.
        ctl_fix_en = 1'b1; ctl_fix = 16'hBEEF;
        req(0, 1'b1, 1'b0, 24'h012345, 16'h0);
        check("rd_busy_t1", {31'd0, p0_if.busy}, 32'd1);
        check("rd_no_early_r", {31'd0, m_if.r}, 32'd0);
        @(negedge clk);
        check("rd_m_r", {31'd0, m_if.r}, 32'd1);
        check("rd_m_addr", {8'd0, m_if.addr}, 32'h012345);
        wait_mbusy(1'b1, 20);
        wait_mbusy(1'b0, 20);
        check("rd_busy_hold", {31'd0, p0_if.busy}, 32'd1);
        @(negedge clk);
        check("rd_busy_fall", {31'd0, p0_if.busy}, 32'd0);
        check("rd_p0_dr", {16'd0, p0_if.dr}, 32'h0000BEEF);
        ctl_fix_en = 1'b0;

        // Single write on p1.
        req(1, 1'b0, 1'b1, 24'h0000FF, 16'hA5A5);
        @(negedge clk);
        check("wr_m_w", {31'd0, m_if.w}, 32'd1);
        check("wr_m_r", {31'd0, m_if.r}, 32'd0);
        check("wr_m_dw", {16'd0, m_if.dw}, 32'h0000A5A5);
        check("wr_m_addr", {8'd0, m_if.addr}, 32'h000000FF);
        wait_idle(40);
        check("wr_p1_dr", {16'd0, p1_if.dr}, 32'd0);
        check("wr_p1_busy", {31'd0, p1_if.busy}, 32'd0);

        // Simultaneous reads: p0 first, p1 granted the cycle after p0 completes.
        req2(24'h000100, 24'h000200);
        check("pair_busy0", {31'd0, p0_if.busy}, 32'd1);
        check("pair_busy1", {31'd0, p1_if.busy}, 32'd1);
        @(negedge clk);
        check("pair_first_addr", {8'd0, m_if.addr}, 32'h100);
        wait_port_idle(0, 40);
        check("pair_gap_r", {31'd0, m_if.r}, 32'd0);
        check("pair_p1_wait", {31'd0, p1_if.busy}, 32'd1);
        @(negedge clk);
        check("pair_second_r", {31'd0, m_if.r}, 32'd1);
        check("pair_second_addr", {8'd0, m_if.addr}, 32'h200);
        wait_idle(40);
        check("pair_p0_dr", {16'd0, p0_if.dr}, 32'h0100 ^ 32'hC3C3);
        check("pair_p1_dr", {16'd0, p1_if.dr}, 32'h0200 ^ 32'hC3C3);

        // Repeat pair: p1 was last granted, so p0 goes first again.
        req2(24'h000300, 24'h000400);
        @(negedge clk);
        check("pair2_first_addr", {8'd0, m_if.addr}, 32'h300);
        wait_idle(60);

        // 100 back-to-back pairs: both ports served every round.
        base = acc_q.size();
        for (int i = 0; i < 100; i++) begin
            req2(24'h001000 + 24'(i), 24'h002000 + 24'(i));
            wait_idle(60);
        end
        check("rr_count", acc_q.size() - base, 32'd200);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (acc_q.size() >= base + 2 * k + 2) begin
                if (acc_q[base + 2 * k] !== 24'h001000 + 24'(k)) bad++;
                if (acc_q[base + 2 * k + 1] !== 24'h002000 + 24'(k)) bad++;
            end else begin
                bad++;
            end
        end
        check("rr_order", bad, 32'd0);
        check("rr_p1_dr", {16'd0, p1_if.dr}, 32'h2063 ^ 32'hC3C3);

        // Pulse while busy is ignored.
        req(0, 1'b1, 1'b0, 24'h000040, 16'h0);
        s0 = n_rpulse;
        req(0, 1'b1, 1'b0, 24'h000001, 16'h0);
        wait_idle(40);
        repeat (3) @(negedge clk);
        check("ign_pulses", n_rpulse - s0, 32'd1);
        check("ign_last_addr", {8'd0, acc_q[acc_q.size() - 1]}, 32'h40);
        check("ign_p0_dr", {16'd0, p0_if.dr}, 32'h0040 ^ 32'hC3C3);

        // r and w together issue a read.
        req(0, 1'b1, 1'b1, 24'h000077, 16'h9999);
        @(negedge clk);
        check("rw_m_r", {31'd0, m_if.r}, 32'd1);
        check("rw_m_w", {31'd0, m_if.w}, 32'd0);
        wait_idle(40);
        check("rw_p0_dr", {16'd0, p0_if.dr}, 32'h0077 ^ 32'hC3C3);

        // Controller busy (refresh) defers the grant.
        refresh = 1'b1;
        s0 = n_wpulse;
        bad = 0;
        req(0, 1'b0, 1'b1, 24'h000055, 16'h1234);
        for (int i = 0; i < 10; i++) begin
            if (m_if.r || m_if.w) bad++;
            @(negedge clk);
        end
        check("ref_hold", bad, 32'd0);
        refresh = 1'b0;
        wait_idle(40);
        check("ref_pulses", n_wpulse - s0, 32'd1);
        check("ref_m_dw", {16'd0, m_if.dw}, 32'h1234);

        // Reset during WAIT_LO abandons the operation.
        lat = 6;
        req(0, 1'b1, 1'b0, 24'h000099, 16'h0);
        wait_mbusy(1'b1, 20);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, p0_if.busy}, 32'd0);
        check("mid_rst_dr", {16'd0, p0_if.dr}, 32'd0);
        check("mid_rst_addr", {8'd0, m_if.addr}, 32'd0);
        check("mid_rst_m_r", {31'd0, m_if.r}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        lat = 3;
        repeat (8) @(negedge clk);
        check("post_rst_busy", {31'd0, p0_if.busy}, 32'd0);
        check("post_rst_dr", {16'd0, p0_if.dr}, 32'd0);
        req(0, 1'b1, 1'b0, 24'h000003, 16'h0);
        @(negedge clk);
        check("post_rst_addr", {8'd0, m_if.addr}, 32'h3);
        wait_idle(40);
        check("post_rst_rd", {16'd0, p0_if.dr}, 32'h0003 ^ 32'hC3C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
